// File: rtl/three_bit_cmp_pkg.sv
// Shared types and constants for the registered 3-bit magnitude comparator.
package three_bit_cmp_pkg;

    localparam int unsigned WIDTH     = 3;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_result_t;

    // Biasing the MSB maps two's-complement ordering onto unsigned ordering.
    function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] v, input logic is_signed);
        return {v[WIDTH-1] ^ is_signed, v[WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/three_bit_cmp_core.sv
// Combinational compare of two WIDTH-bit operands, unsigned or two's complement.
module three_bit_cmp_core
    import three_bit_cmp_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_mode_i,
    output cmp_result_t      result_o
);

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;

    always_comb begin
        a_key    = order_key(a_i, signed_mode_i);
        b_key    = order_key(b_i, signed_mode_i);
        result_o = CMP_EQ;
        if (a_i != b_i) begin
            result_o = (a_key > b_key) ? CMP_GT : CMP_LT;
        end
    end

endmodule

// File: rtl/three_bit_cmp.sv
// Registered one-hot comparator with 1-cycle latency.
// Optional saturating result counters enabled by defining THREE_BIT_CMP_STATS_EN.
module three_bit_cmp
    import three_bit_cmp_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             GT,
    output logic             LT,
    output logic             EQ,
`ifdef THREE_BIT_CMP_STATS_EN
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
`endif
    output logic             out_valid
);

    cmp_result_t res;

    logic gt_q, gt_d;
    logic lt_q, lt_d;
    logic eq_q, eq_d;
    logic out_valid_q, out_valid_d;

    three_bit_cmp_core u_core (
        .a_i          (A),
        .b_i          (B),
        .signed_mode_i(signed_mode),
        .result_o     (res)
    );

    always_comb begin
        gt_d        = gt_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            gt_d = (res == CMP_GT);
            lt_d = (res == CMP_LT);
            eq_d = (res == CMP_EQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign GT        = gt_q;
    assign LT        = lt_q;
    assign EQ        = eq_q;
    assign out_valid = out_valid_q;

`ifdef THREE_BIT_CMP_STATS_EN
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
    logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;

    // Counters advance on the same edge that registers the matching result.
    always_comb begin
        gt_cnt_d = gt_cnt_q;
        lt_cnt_d = lt_cnt_q;
        eq_cnt_d = eq_cnt_q;
        if (in_valid) begin
            if (res == CMP_GT && gt_cnt_q != '1) gt_cnt_d = gt_cnt_q + CNT_W'(1);
            if (res == CMP_LT && lt_cnt_q != '1) lt_cnt_d = lt_cnt_q + CNT_W'(1);
            if (res == CMP_EQ && eq_cnt_q != '1) eq_cnt_d = eq_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_cnt_q <= '0;
            lt_cnt_q <= '0;
            eq_cnt_q <= '0;
        end else begin
            gt_cnt_q <= gt_cnt_d;
            lt_cnt_q <= lt_cnt_d;
            eq_cnt_q <= eq_cnt_d;
        end
    end

    assign gt_cnt = gt_cnt_q;
    assign lt_cnt = lt_cnt_q;
    assign eq_cnt = eq_cnt_q;
`endif

endmodule

// File: tb/tb_three_bit_cmp.sv
// Directed self-checking bench for three_bit_cmp; stats checks need THREE_BIT_CMP_STATS_EN.
module tb_three_bit_cmp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] A = 3'd0;
    logic [2:0] B = 3'd0;
    logic       signed_mode = 1'b0;
    logic       GT, LT, EQ, out_valid;
`ifdef THREE_BIT_CMP_STATS_EN
    logic [7:0] gt_cnt, lt_cnt, eq_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    three_bit_cmp #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .A          (A),
        .B          (B),
        .signed_mode(signed_mode),
        .GT         (GT),
        .LT         (LT),
        .EQ         (EQ),
`ifdef THREE_BIT_CMP_STATS_EN
        .gt_cnt     (gt_cnt),
        .lt_cnt     (lt_cnt),
        .eq_cnt     (eq_cnt),
`endif
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    // Result word compared below is {GT, LT, EQ, out_valid}.
    always @(negedge clk) begin
        if (rst_n && out_valid === 1'b1) begin
            n_checks++;
            if (int'(GT) + int'(LT) + int'(EQ) != 1) begin
                n_fail++;
                $display("FAIL onehot t=%0t got GT=%b LT=%b EQ=%b expected exactly one set", $time, GT, LT, EQ);
            end
        end
    end

    task automatic test_reset();
        #3;
        n_checks++;
        if ({GT, LT, EQ, out_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state got %b expected 0000", {GT, LT, EQ, out_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({GT, LT, EQ, out_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release_idle got %b expected 0000", {GT, LT, EQ, out_valid});
        end
    endtask

    task automatic test_unsigned_exhaustive();
        logic [3:0] exp;
        signed_mode = 1'b0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                A = 3'(a);
                B = 3'(b);
                in_valid = 1'b1;
                @(posedge clk); #1;
                exp = (a > b) ? 4'b1001 : (a < b) ? 4'b0101 : 4'b0011;
                n_checks++;
                if ({GT, LT, EQ, out_valid} !== exp) begin
                    n_fail++;
                    $display("FAIL unsigned A=%0d B=%0d got %b expected %b", a, b, {GT, LT, EQ, out_valid}, exp);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_signed();
        // {A, B, signed_mode, expected GT/LT/EQ}
        logic [9:0] vec [9] = '{
            {3'b111, 3'b001, 1'b0, 3'b100},
            {3'b111, 3'b001, 1'b1, 3'b010},
            {3'b100, 3'b011, 1'b1, 3'b010},
            {3'b011, 3'b100, 1'b1, 3'b100},
            {3'b100, 3'b100, 1'b1, 3'b001},
            {3'b101, 3'b010, 1'b1, 3'b010},
            {3'b110, 3'b101, 1'b1, 3'b100},
            {3'b000, 3'b111, 1'b1, 3'b100},
            {3'b000, 3'b111, 1'b0, 3'b010}
        };
        for (int i = 0; i < 9; i++) begin
            A = vec[i][9:7];
            B = vec[i][6:4];
            signed_mode = vec[i][3];
            in_valid = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if ({GT, LT, EQ, out_valid} !== {vec[i][2:0], 1'b1}) begin
                n_fail++;
                $display("FAIL signed[%0d] A=%b B=%b sm=%b got %b expected %b",
                         i, vec[i][9:7], vec[i][6:4], vec[i][3], {GT, LT, EQ, out_valid}, {vec[i][2:0], 1'b1});
            end
        end
        in_valid = 1'b0;
        signed_mode = 1'b0;
    endtask

    task automatic test_hold();
        A = 3'd1; B = 3'd6; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({GT, LT, EQ, out_valid} !== 4'b0101) begin
            n_fail++;
            $display("FAIL hold_load got %b expected 0101", {GT, LT, EQ, out_valid});
        end
        in_valid = 1'b0; A = 3'd7; B = 3'd0; signed_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({GT, LT, EQ, out_valid} !== 4'b0100) begin
                n_fail++;
                $display("FAIL hold_cycle%0d got %b expected 0100", i, {GT, LT, EQ, out_valid});
            end
        end
        signed_mode = 1'b0;
    endtask

    task automatic test_async_reset();
        A = 3'd6; B = 3'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({GT, LT, EQ, out_valid} !== 4'b1001) begin
            n_fail++;
            $display("FAIL areset_pre got %b expected 1001", {GT, LT, EQ, out_valid});
        end
        A = 3'd0; B = 3'd5;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({GT, LT, EQ, out_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL areset_immediate got %b expected 0000", {GT, LT, EQ, out_valid});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({GT, LT, EQ, out_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL areset_held got %b expected 0000", {GT, LT, EQ, out_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({GT, LT, EQ, out_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL areset_no_pulse got %b expected 0000", {GT, LT, EQ, out_valid});
        end
        A = 3'd2; B = 3'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({GT, LT, EQ, out_valid} !== 4'b0011) begin
            n_fail++;
            $display("FAIL areset_resume got %b expected 0011", {GT, LT, EQ, out_valid});
        end
        in_valid = 1'b0;
    endtask

`ifdef THREE_BIT_CMP_STATS_EN
    task automatic test_stats();
        @(negedge clk); rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gt_cnt, lt_cnt, eq_cnt} !== 24'd0) begin
            n_fail++;
            $display("FAIL stats_reset got gt=%0d lt=%0d eq=%0d expected 0 0 0", gt_cnt, lt_cnt, eq_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            A = 3'(i % 8); B = 3'(i % 8); signed_mode = 1'(i % 2); in_valid = 1'b1;
            @(posedge clk); #1;
            if (i == 9) begin
                n_checks++;
                if (eq_cnt !== 8'd10) begin
                    n_fail++;
                    $display("FAIL stats_eq10 got %0d expected 10", eq_cnt);
                end
            end
        end
        n_checks++;
        if ({gt_cnt, lt_cnt, eq_cnt} !== {8'd0, 8'd0, 8'd255}) begin
            n_fail++;
            $display("FAIL stats_sat got gt=%0d lt=%0d eq=%0d expected 0 0 255", gt_cnt, lt_cnt, eq_cnt);
        end
        A = 3'd4; B = 3'd1; signed_mode = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({gt_cnt, lt_cnt, eq_cnt} !== {8'd1, 8'd0, 8'd255}) begin
            n_fail++;
            $display("FAIL stats_gt1 got gt=%0d lt=%0d eq=%0d expected 1 0 255", gt_cnt, lt_cnt, eq_cnt);
        end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned_exhaustive();
        test_signed();
        test_hold();
        test_async_reset();
`ifdef THREE_BIT_CMP_STATS_EN
        test_stats();
`endif
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/three_bit_cmp.md
# three_bit_cmp

Registered 3-bit magnitude comparator. Compares operands A and B each valid cycle and reports exactly one of GT, LT, EQ one clock later, with selectable unsigned or two's-complement interpretation. Sits as a leaf datapath block feeding control logic that needs a clean, registered, one-hot compare result.

## Interface

Parameters:
- WIDTH, 3, operand width; fixed at 3 for this block, taken from the package.
- CNT_W, 8, width of each statistics counter (only with THREE_BIT_CMP_STATS_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  A/B/signed_mode valid this cycle.
- A  input  3  operand A.
- B  input  3  operand B.
- signed_mode  input  1  0 = unsigned (0..7), 1 = two's complement (-4..3).
- GT  output  1  A > B.
- LT  output  1  A < B.
- EQ  output  1  A == B.
- out_valid  output  1  GT/LT/EQ hold a fresh result this cycle.
- gt_cnt, lt_cnt, eq_cnt  output  CNT_W each  result counters (only with THREE_BIT_CMP_STATS_EN).

## Operation

- On each rising clk with in_valid=1: compute compare of A vs B under signed_mode; register GT/LT/EQ; set out_valid=1.
- On rising clk with in_valid=0: GT/LT/EQ hold previous values; out_valid=0.
- After the first valid result, exactly one of GT/LT/EQ is 1 (one-hot invariant).
- Unsigned: plain 3-bit magnitude compare. Signed: MSB is sign; 3'b100 = -4 is the minimum, 3'b011 = +3 the maximum.
- EQ is independent of signed_mode (bitwise equality).
- A, B, signed_mode are sampled only when in_valid=1; changes while in_valid=0 have no effect.

## Timing

- Latency: 1 cycle from in_valid sample to out_valid/result.
- Throughput: one compare per cycle, back-to-back valid allowed; no backpressure.
- Reset (rst_n low, asynchronous assert): GT=0, LT=0, EQ=0, out_valid=0, counters=0 immediately, independent of clk.
- Reset release synchronous to clk; first compare sampled on the first rising edge with rst_n=1 and in_valid=1.
- Reset mid-operation: in-flight result discarded; outputs return to reset values; no out_valid pulse for the discarded sample.

## Configuration

- THREE_BIT_CMP_STATS_EN defined: ports gt_cnt, lt_cnt, eq_cnt present; each increments by 1 on every registered result of its kind (same edge out_valid rises); saturates at 2^CNT_W-1, never wraps; cleared only by rst_n.
- Not defined: counter ports and logic absent; block is comparator only.

## Structure

- Package three_bit_cmp_pkg: WIDTH=3, CNT_W default 8, enum cmp_result_t {CMP_EQ, CMP_LT, CMP_GT}.
- One sub-module, three_bit_cmp_core: purely combinational compare of A, B, signed_mode returning cmp_result_t; top level holds registers, valid pipeline and optional counters.

## Test plan

- Exhaustive unsigned: all 64 {A,B} combos, signed_mode=0, in_valid=1 back-to-back -> each result one cycle later, e.g. A=5,B=2 -> GT=1,LT=0,EQ=0; A=3,B=3 -> EQ=1.
- Signed contrast: A=3'b111,B=3'b001 -> signed_mode=0 gives GT=1; signed_mode=1 (-1 vs +1) gives LT=1; A=3'b100,B=3'b011 signed -> LT=1.
- Hold: valid A=1,B=6 (LT=1) then in_valid=0 with A=7,B=0 for 3 cycles -> LT stays 1, out_valid=0.
- Async reset mid-stream: assert rst_n low between edges after GT result -> GT/LT/EQ/out_valid=0 immediately, before next edge.
- Stats (THREE_BIT_CMP_STATS_EN, CNT_W=8): 300 consecutive EQ compares -> eq_cnt=255 saturated, gt_cnt=lt_cnt=0.
- One-hot check across all scenarios: GT+LT+EQ == 1 whenever out_valid=1.
